fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction fetch and sequencing stage that feeds the opcode decoder of the accumulator CPU. It holds the program counter (PC) and instruction register (IR), and fetches each instruction from instruction memory over a req/ack handshake. It presents the 3-bit opcode to the decoder and issues a one-cycle execute strobe. It then resolves JMP/JZ/JC using the decoder's jump output and the status flags.

## Interface
- `AW`, default 5: address / PC / operand width.
- `OW`, default 3: opcode width; instruction word is `OW+AW` bits, opcode in the MSBs.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `run_i`  in  1  start/continue execution; level-sensitive.
- `imem_req_o`  out  1  instruction read request.
- `imem_addr_o`  out  AW  read address; equals PC.
- `imem_ack_i`  in  1  read data valid; qualifies `imem_data_i`.
- `imem_data_i`  in  OW+AW  instruction word.
- `op_o`  out  OW  opcode to the decoder, driven from IR[OW+AW-1:AW].
- `operand_o`  out  AW  address field, driven from IR[AW-1:0].
- `exec_o`  out  1  one-cycle strobe; decoder outputs are valid and act only while it is high.
- `jmp_i`  in  1  jump request from the decoder.
- `z_i`  in  1  zero flag from the status register.
- `c_i`  in  1  carry flag from the status register.
- `pc_o`  out  AW  current PC.
- `busy_o`  out  1  high in FETCH or EXEC.
- `halted_o`  out  1  high in HALT.

## Operation
- State machine:
  - IDLE: wait for `run_i` = 1, then go to FETCH.
  - FETCH:
    - `imem_req_o` = 1 and `imem_addr_o` = PC.
    - On `imem_ack_i` = 1: IR ← `imem_data_i`; PC ← PC+1, modulo 2^AW; go to EXEC.
  - EXEC:
    - `exec_o` = 1 for exactly this cycle.
    - Branch resolution is described below.
    - Next state: opcode 111 → HALT; else `run_i` = 0 → IDLE; else → FETCH.
  - HALT: terminal. Nothing is issued. Only `rst_ni` exits this state.
- Branch resolution in EXEC: `take` = `jmp_i` & (op==100 | (op==101 & `z_i`) | (op==110 & `c_i`)).
  - If `take`: PC ← `operand_o`. This overrides the increment made in FETCH.
  - `jmp_i` = 1 with any other opcode is ignored.
- Flags are sampled combinationally in the EXEC cycle, so they reflect the result of the previous instruction.
- Opcode 111 is HALT. The decoder produces no writes for it.
- `op_o` and `operand_o` hold the IR contents between strobes. Downstream logic must qualify every write with `exec_o`.
- PC wraps from 2^AW−1 to 0 with no error.

## Timing
- Reset values (asynchronous): state = IDLE, PC = 0, IR = 0.
  - All outputs 0: `imem_req_o`, `imem_addr_o`, `op_o`, `operand_o`, `exec_o`, `pc_o`, `busy_o`, `halted_o`.
- Handshake rules:
  - `imem_req_o` rises on the first FETCH cycle and stays high, with `imem_addr_o` stable, until the edge where `imem_ack_i` = 1.
  - `imem_ack_i` is sampled only while `imem_req_o` = 1. Ack outside FETCH is ignored.
  - Ack in the first FETCH cycle is allowed, so the minimum is one FETCH cycle.
- Latency: one instruction takes (1 + memory wait cycles) FETCH cycles plus 1 EXEC cycle. The minimum is 2 cycles per instruction. There is no fetch/execute overlap.
- `run_i` falling:
  - During FETCH: the current fetch completes and its instruction executes; the FSM then goes to IDLE.
  - In IDLE: the PC is retained, and execution resumes from it when `run_i` rises.
- Reset mid-fetch:
  - `imem_req_o` drops immediately, without waiting for a clock edge.
  - A late ack after reset is ignored, because the FSM is in IDLE.
- `exec_o` is never high on two consecutive cycles.

## Test plan
- Reset and idle:
  - Stimulus: assert `rst_ni` = 0 mid-stream, then release with `run_i` = 0 for 5 cycles.
  - Required: all outputs 0; `imem_req_o` stays 0.
- Straight-line fetch with wait states:
  - Stimulus: `run_i` = 1; memory acks 3 cycles after req; words 0x45 and 0x1F at addresses 0 and 1.
  - Required, first instruction: `op_o` = 010, `operand_o` = 5, and one `exec_o` pulse.
  - Required, second instruction: `op_o` = 000, `operand_o` = 31; `pc_o` sequence 0 → 1 → 2.
- Conditional branch:
  - Stimulus: JZ to 0x0C (word 0xAC) with `jmp_i` = 1, run once with `z_i` = 1 and once with `z_i` = 0.
  - Required: the next `imem_addr_o` is 0x0C when taken, and PC+1 when not taken.
- JMP and wrap-around:
  - Stimulus: JMP to 31; the instruction at 31 is ADD.
  - Required: the next fetch address is 0.
- HALT:
  - Stimulus: fetch word 0xE0.
  - Required: one `exec_o` pulse, then `halted_o` = 1 and `busy_o` = 0; no further `imem_req_o` for 20 cycles, even with `run_i` = 1.
- Reset during pending fetch:
  - Stimulus: assert `rst_ni` low while `imem_req_o` = 1 and before ack; then ack arrives 1 cycle after release.
  - Required: `imem_req_o` falls asynchronously; IR is unchanged (0); no `exec_o` pulse.

Source files
------------

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction fetch and sequencing stage for the accumulator CPU. Holds the
// program counter (PC) and instruction register (IR). Fetches one instruction
// word over a req/ack handshake, presents the opcode and address field to the
// decoder with a one-cycle execute strobe, and resolves JMP/JZ/JC.
//
// Handshake (imem): imem_req_o is raised on the first FETCH cycle and held,
// with imem_addr_o stable, until the rising edge where imem_ack_i = 1. That
// edge captures imem_data_i into IR. imem_ack_i is ignored whenever
// imem_req_o = 0.
//
// Ports
//   clk_i        clock; all state updates on the rising edge
//   rst_ni       asynchronous active-low reset
//   run_i        level-sensitive start/continue
//   imem_req_o   instruction read request
//   imem_addr_o  read address (= PC)
//   imem_ack_i   read data valid
//   imem_data_i  instruction word {opcode, address}
//   op_o         opcode (IR MSBs)
//   operand_o    address field (IR LSBs)
//   exec_o       one-cycle execute strobe
//   jmp_i        jump request from the decoder
//   z_i, c_i     zero / carry flags
//   pc_o         current PC
//   busy_o       high in FETCH or EXEC
//   halted_o     high in HALT
//   state_o      FSM state for observation (0 IDLE, 1 FETCH, 2 EXEC, 3 HALT)
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int AW = 5,
  parameter int OW = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  output logic             imem_req_o,
  output logic [AW-1:0]    imem_addr_o,
  input  logic             imem_ack_i,
  input  logic [OW+AW-1:0] imem_data_i,
  output logic [OW-1:0]    op_o,
  output logic [AW-1:0]    operand_o,
  output logic             exec_o,
  input  logic             jmp_i,
  input  logic             z_i,
  input  logic             c_i,
  output logic [AW-1:0]    pc_o,
  output logic             busy_o,
  output logic             halted_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [OW-1:0] OP_JMP  = OW'(4);
  localparam logic [OW-1:0] OP_JZ   = OW'(5);
  localparam logic [OW-1:0] OP_JC   = OW'(6);
  localparam logic [OW-1:0] OP_HALT = OW'(7);

  state_t           state;
  logic [AW-1:0]    pc;
  logic [OW+AW-1:0] ir;
  logic             take;

  assign op_o        = ir[OW+AW-1:AW];
  assign operand_o   = ir[AW-1:0];
  assign pc_o        = pc;
  assign imem_addr_o = pc;
  assign state_o     = state;

  // Flags are used as they stand during EXEC, i.e. the result of the
  // previous instruction. jmp_i paired with a non-branch opcode is ignored.
  assign take = jmp_i & ((op_o == OP_JMP) |
                         ((op_o == OP_JZ) & z_i) |
                         ((op_o == OP_JC) & c_i));

  // Outputs req/exec/busy/halted are registered and updated together with
  // the state, so each one is exactly the decode of the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      pc         <= '0;
      ir         <= '0;
      imem_req_o <= 1'b0;
      exec_o     <= 1'b0;
      busy_o     <= 1'b0;
      halted_o   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run_i) begin
            state      <= S_FETCH;
            imem_req_o <= 1'b1;
            busy_o     <= 1'b1;
          end
        end

        S_FETCH: begin
          if (imem_ack_i) begin
            ir         <= imem_data_i;
            pc         <= pc + AW'(1);
            state      <= S_EXEC;
            imem_req_o <= 1'b0;
            exec_o     <= 1'b1;
          end
        end

        S_EXEC: begin
          exec_o <= 1'b0;
          // Branch target overrides the increment done at the fetch edge.
          if (take) begin
            pc <= operand_o;
          end
          if (op_o == OP_HALT) begin
            state    <= S_HALT;
            busy_o   <= 1'b0;
            halted_o <= 1'b1;
          end else if (!run_i) begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end else begin
            state      <= S_FETCH;
            imem_req_o <= 1'b1;
          end
        end

        S_HALT: begin
          // Terminal; only reset leaves this state.
          state <= S_HALT;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed bench for fetch_sequencer (AW=5, OW=3). Inputs are driven and
// outputs sampled on the falling clock edge, away from the active edge.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam int AW = 5;
  localparam int OW = 3;

  logic          clk;
  logic          rst_n;
  logic          run;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [7:0]    imem_data;
  logic [OW-1:0] op;
  logic [AW-1:0] operand;
  logic          exec;
  logic          jmp;
  logic          z;
  logic          c;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;
  logic [1:0]    state;

  int n_checks;
  int n_fail;

  fetch_sequencer #(.AW(AW), .OW(OW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .run_i       (run),
    .imem_req_o  (imem_req),
    .imem_addr_o (imem_addr),
    .imem_ack_i  (imem_ack),
    .imem_data_i (imem_data),
    .op_o        (op),
    .operand_o   (operand),
    .exec_o      (exec),
    .jmp_i       (jmp),
    .z_i         (z),
    .c_i         (c),
    .pc_o        (pc),
    .busy_o      (busy),
    .halted_o    (halted),
    .state_o     (state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},     32'(imem_req),  32'h0);
    check({tag, "_addr"},    32'(imem_addr), 32'h0);
    check({tag, "_op"},      32'(op),        32'h0);
    check({tag, "_operand"}, 32'(operand),   32'h0);
    check({tag, "_exec"},    32'(exec),      32'h0);
    check({tag, "_pc"},      32'(pc),        32'h0);
    check({tag, "_busy"},    32'(busy),      32'h0);
    check({tag, "_halted"},  32'(halted),    32'h0);
  endtask

  // Memory responder: waits (bounded) for req, checks the address, holds ack
  // low for 'waits' cycles, then acks with 'word'. Returns at the falling edge
  // of the EXEC cycle with the strobe and IR fields checked.
  task automatic serve(input string tag, input logic [AW-1:0] exp_addr,
                       input logic [7:0] word, input int waits);
    int n;
    n = 0;
    while (!imem_req && n < 10) begin
      step();
      n++;
    end
    check({tag, "_req_seen"}, 32'(imem_req), 32'h1);
    check({tag, "_addr"}, 32'(imem_addr), 32'(exp_addr));
    for (int i = 0; i < waits; i++) begin
      step();
      check({tag, "_req_held"}, 32'(imem_req), 32'h1);
      check({tag, "_addr_held"}, 32'(imem_addr), 32'(exp_addr));
      check({tag, "_no_exec_wait"}, 32'(exec), 32'h0);
    end
    imem_ack  = 1'b1;
    imem_data = word;
    step();
    imem_ack  = 1'b0;
    imem_data = 8'h00;
    check({tag, "_exec"}, 32'(exec), 32'h1);
    check({tag, "_op"}, 32'(op), 32'(word[7:5]));
    check({tag, "_operand"}, 32'(operand), 32'(word[4:0]));
    check({tag, "_req_drop"}, 32'(imem_req), 32'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    run       = 1'b0;
    imem_ack  = 1'b0;
    imem_data = 8'h00;
    jmp       = 1'b0;
    z         = 1'b0;
    c         = 1'b0;

    // Reset and idle.
    step();
    step();
    check_all_zero("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_req", 32'(imem_req), 32'h0);
      check("idle_busy", 32'(busy), 32'h0);
    end
    check_all_zero("idle");

    // Straight-line fetch with 3 wait states.
    run = 1'b1;
    serve("i0", 5'd0, 8'h45, 3);
    check("i0_pc", 32'(pc), 32'd1);
    step();
    check("i0_exec_off", 32'(exec), 32'h0);
    check("i0_busy", 32'(busy), 32'h1);
    serve("i1", 5'd1, 8'h1F, 3);
    check("i1_pc", 32'(pc), 32'd2);
    step();
    check("i1_exec_off", 32'(exec), 32'h0);

    // JZ taken (z=1).
    serve("jz_t", 5'd2, 8'hAC, 0);
    jmp = 1'b1;
    z   = 1'b1;
    step();
    jmp = 1'b0;
    z   = 1'b0;
    check("jz_taken_addr", 32'(imem_addr), 32'h0C);
    check("jz_taken_exec_off", 32'(exec), 32'h0);

    // JZ not taken (z=0).
    serve("jz_n", 5'h0C, 8'hAC, 1);
    jmp = 1'b1;
    step();
    jmp = 1'b0;
    check("jz_not_taken_addr", 32'(imem_addr), 32'h0D);

    // jmp_i with a non-branch opcode is ignored.
    serve("nb", 5'h0D, 8'h45, 0);
    jmp = 1'b1;
    z   = 1'b1;
    c   = 1'b1;
    step();
    jmp = 1'b0;
    z   = 1'b0;
    c   = 1'b0;
    check("nonbranch_addr", 32'(imem_addr), 32'h0E);

    // JC taken (c=1) to 3.
    serve("jc", 5'h0E, 8'hC3, 0);
    jmp = 1'b1;
    c   = 1'b1;
    step();
    jmp = 1'b0;
    c   = 1'b0;
    check("jc_taken_addr", 32'(imem_addr), 32'h03);

    // JMP to 31, then ADD at 31 wraps PC to 0.
    serve("jmp", 5'd3, 8'h9F, 2);
    jmp = 1'b1;
    step();
    jmp = 1'b0;
    check("jmp_addr", 32'(imem_addr), 32'h1F);
    serve("add31", 5'h1F, 8'h23, 0);
    check("wrap_pc", 32'(pc), 32'h00);
    step();
    check("wrap_addr", 32'(imem_addr), 32'h00);
    check("wrap_req", 32'(imem_req), 32'h1);

    // run_i falls during FETCH: fetch completes, executes, then IDLE.
    run = 1'b0;
    serve("stop", 5'd0, 8'h45, 1);
    step();
    check("stop_req", 32'(imem_req), 32'h0);
    check("stop_busy", 32'(busy), 32'h0);
    check("stop_state", 32'(state), 32'd0);
    check("stop_pc", 32'(pc), 32'd1);
    step();
    step();
    check("stop_req_hold", 32'(imem_req), 32'h0);
    check("stop_pc_hold", 32'(pc), 32'd1);

    // Resume from retained PC, then HALT.
    run = 1'b1;
    serve("halt", 5'd1, 8'hE0, 0);
    step();
    check("halt_exec_off", 32'(exec), 32'h0);
    check("halt_halted", 32'(halted), 32'h1);
    check("halt_busy", 32'(busy), 32'h0);
    check("halt_state", 32'(state), 32'd3);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) imem_ack = 1'b1;
      step();
      check("halt_no_req", 32'(imem_req), 32'h0);
      check("halt_no_exec", 32'(exec), 32'h0);
    end
    imem_ack = 1'b0;
    check("halt_still", 32'(halted), 32'h1);

    // Reset exits HALT; start a fetch, reset while it is pending.
    rst_n = 1'b0;
    step();
    check("halt_reset_halted", 32'(halted), 32'h0);
    rst_n = 1'b1;
    step();
    check("pend_req", 32'(imem_req), 32'h1);
    check("pend_addr", 32'(imem_addr), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_req_drop", 32'(imem_req), 32'h0);
    check("async_busy_drop", 32'(busy), 32'h0);
    step();
    rst_n = 1'b1;
    run   = 1'b0;
    step();
    imem_ack  = 1'b1;
    imem_data = 8'hFF;
    step();
    imem_ack  = 1'b0;
    imem_data = 8'h00;
    check("late_ack_exec", 32'(exec), 32'h0);
    check("late_ack_op", 32'(op), 32'h0);
    check("late_ack_operand", 32'(operand), 32'h0);
    check("late_ack_pc", 32'(pc), 32'h0);
    step();
    check("late_ack_exec2", 32'(exec), 32'h0);
    check_all_zero("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog: guarantees termination even if the sequence stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
